// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer and its slot splitter.
package fetch_ctrl_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} fetch_state_e;

  localparam int unsigned FETCH_BYTES = 8;

endpackage

// File: rtl/fetch_ctrl_if.sv
// I-cache request/response bus between the fetch sequencer (master) and the I-cache (slave).
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic        icache_req;
  addr_t       icache_addr;
  logic        icache_gnt;
  logic        icache_rvalid;
  logic [63:0] icache_rdata;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_gnt,
    input  icache_rvalid,
    input  icache_rdata
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_gnt,
    output icache_rvalid,
    output icache_rdata
  );

endinterface

// File: rtl/fetch_slot_split.sv
// Splits one 8-byte I-cache response into two instruction slots and reports the PC advance.
module fetch_slot_split
  import fetch_ctrl_pkg::*;
(
  input  addr_t       req_pc_i,
  input  logic [63:0] rdata_i,
  input  logic        kill_i,
  output logic        inst_valid1_o,
  output logic        inst_valid2_o,
  output inst_t       inst_data1_o,
  output inst_t       inst_data2_o,
  output logic [3:0]  pc_incr_o
);

  logic upper;
  logic unused_pc;

  assign upper     = req_pc_i[2];
  assign unused_pc = ^{req_pc_i[63:3], req_pc_i[1:0]};

  always_comb begin
    inst_valid1_o = 1'b0;
    inst_valid2_o = 1'b0;
    inst_data1_o  = '0;
    inst_data2_o  = '0;
    pc_incr_o     = upper ? 4'(FETCH_BYTES / 2) : 4'(FETCH_BYTES);
    if (!kill_i) begin
      // A PC in the upper word leaves only the high instruction of the packet usable.
      inst_valid1_o = 1'b1;
      inst_valid2_o = !upper;
      inst_data1_o  = upper ? rdata_i[63:32] : rdata_i[31:0];
      inst_data2_o  = upper ? '0 : rdata_i[63:32];
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one aligned I-cache request at a time and applies
// redirects. Define FETCH_PERF_CNT_EN to add fetched-packet and stall-cycle counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t       RESET_PC = 64'h8000_0000,
  parameter int unsigned FIFO_CNT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  addr_t                         redirect_pc,
  input  logic [$clog2(FIFO_CNT+1)-1:0] fifo_room,
  fetch_ctrl_if.master                  ic_bus,
  output addr_t                         fetch_pc,
  output logic                          inst_valid1,
  output logic                          inst_valid2,
  output inst_t                         inst_data1,
  output inst_t                         inst_data2,
  output logic                          flush_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]                   perf_fetch_pkts,
  output logic [63:0]                   perf_stall_cycles
`endif
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        req_pc_q, req_pc_d;
  logic         req_q, req_d;
  addr_t        redir_pc;
  logic         kill;
  logic         room_ok;
  logic [3:0]   pc_incr;
  logic         unused_redir;

  assign redir_pc     = {redirect_pc[63:2], 2'b00};
  assign unused_redir = ^redirect_pc[1:0];
  assign room_ok      = 32'(fifo_room) >= 32'd2;
  assign flush_id     = redirect_valid;
  assign fetch_pc     = req_pc_q;

  assign ic_bus.icache_req  = req_q;
  assign ic_bus.icache_addr = {pc_q[63:3], 3'b000};

  // Stale responses (DROP) and responses coinciding with a redirect are consumed silently.
  assign kill = !(state_q == StWait && ic_bus.icache_rvalid && !redirect_valid);

  fetch_slot_split u_split (
    .req_pc_i      (req_pc_q),
    .rdata_i       (ic_bus.icache_rdata),
    .kill_i        (kill),
    .inst_valid1_o (inst_valid1),
    .inst_valid2_o (inst_valid2),
    .inst_data1_o  (inst_data1),
    .inst_data2_o  (inst_data2),
    .pc_incr_o     (pc_incr)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      StIdle: if (!redirect_valid && room_ok) state_d = StReq;
      StReq: begin
        if (ic_bus.icache_gnt) begin
          req_pc_d = pc_q;
          state_d  = redirect_valid ? StDrop : StWait;
        end else if (redirect_valid) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (ic_bus.icache_rvalid) begin
          state_d = StIdle;
          pc_d    = req_pc_q + addr_t'(pc_incr);
        end else if (redirect_valid) begin
          state_d = StDrop;
        end
      end
      StDrop: if (ic_bus.icache_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (redirect_valid) pc_d = redir_pc;
    req_d = (state_d == StReq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      req_q    <= req_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] pkts_q, pkts_d;
  logic [63:0] stall_q, stall_d;

  always_comb begin
    pkts_d  = pkts_q + 64'(inst_valid1);
    stall_d = stall_q + 64'(state_q == StIdle && !room_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q  <= '0;
      stall_q <= '0;
    end else begin
      pkts_q  <= pkts_d;
      stall_q <= stall_d;
    end
  end

  assign perf_fetch_pkts   = pkts_q;
  assign perf_stall_cycles = stall_q;
`endif

endmodule
